rs_wakeup_shift: RTL and testbench
==================================

# rs_wakeup_shift

Parametrised reservation-station wakeup array for the issue stage. It holds ENTRIES instruction slots, each with a left and a right source operand. It compares every operand tag against CHANNELS result-tag broadcasts and loads a per-operand latency shift register on a match, so that dependents wake exactly when the producer's result is available. It also supports speculative-wakeup cancel (load miss), per-entry issue tracking and request generation towards the select/arbiter logic.

## Interface
Parameters:
- ENTRIES, 8, number of RS slots (≥2)
- CHANNELS, 5, number of broadcast ports (alu1, alu2, bra, ldst, mul)
- TAG_W, 5, physical tag width
- DLY_LEN, 8, delay shift-register width; producer latency L range 0..DLY_LEN-1
- IDX_W, $clog2(ENTRIES), slot index width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alloc_vld  in  1  write a new instruction into slot alloc_idx
- alloc_idx  in  IDX_W  target slot
- alloc_tag_l / alloc_tag_r  in  TAG_W  source tags
- alloc_rdy_l / alloc_rdy_r  in  1  operand already available at dispatch
- bcast_vld  in  CHANNELS  per-channel broadcast valid
- bcast_tag  in  CHANNELS*TAG_W  channel c at [c*TAG_W +: TAG_W]
- bcast_dly  in  CHANNELS*DLY_LEN  one-hot 1<<L, channel c at [c*DLY_LEN +: DLY_LEN]
- cancel_vld  in  1  squash speculative wakeups from cancel_tag
- cancel_tag  in  TAG_W  tag being cancelled
- grant_vld  in  1  select logic issued slot grant_idx
- grant_idx  in  IDX_W  issued slot
- free_vld  in  1  release slot free_idx
- free_idx  in  IDX_W  released slot
- req  out  ENTRIES  issue request per slot
- rdy_l / rdy_r  out  ENTRIES  operand ready per slot
- shift_l / shift_r  out  ENTRIES  operand shift register non-zero (counting down)
- busy  out  ENTRIES  slot occupied
- free_cnt  out  IDX_W+1  number of non-busy slots

## Operation
- Per slot state: busy, issued, and per operand: tag, rdy_q (sticky), SH[DLY_LEN-1:0].
- Outputs: rdy_x = rdy_q | SH[0]; shift_x = |SH; req = busy & ~issued & rdy_l & rdy_r; free_cnt = ENTRIES − popcount(busy).
- Match: operand busy, rdy_x=0, SH=0, and bcast_vld[c] with bcast_tag[c]==tag. Load SH <= bcast_dly[c]. Multiple matching channels: lowest c wins.
- Shift: SH != 0 and no load -> SH <= SH>>1. When SH[0]=1, rdy_q <= 1.
- Operands with rdy_x=1 ignore further matches.
- Alloc: busy<=1, issued<=0, tags written, rdy_q<=alloc_rdy_x, SH<=0. A same-cycle broadcast matching an alloc tag with alloc_rdy_x=0 loads SH in the same edge. Broadcasts are not missed.
- Cancel: any operand with rdy_q=0, SH!=0, tag==cancel_tag -> SH<=0 and it waits for a rebroadcast. If a broadcast of the same tag arrives in the same cycle, the broadcast load wins.
- Grant: issued[grant_idx]<=1. A grant to a slot with req=0 is ignored.
- Free: busy<=0, issued<=0, rdy_q<=0, SH<=0.
- Priority on the same slot in the same cycle: alloc > free > grant.
- Alloc to a busy slot overwrites it; avoiding this is the upstream allocator's responsibility.

## Timing
- Reset (async): busy, issued, rdy_q and SH are all 0. Outputs: req=0, rdy_l=0, rdy_r=0, shift_l=0, shift_r=0, busy=0, free_cnt=ENTRIES.
- Match at edge t with latency L: SH=1<<L visible after t. rdy_x and req rise L cycles later, i.e. in cycle t+1+L. L=0 gives wakeup in the next cycle.
- alloc_rdy_l=alloc_rdy_r=1: req is high in the cycle after alloc.
- Grant in cycle t: req for that slot is low from t+1.
- Cancel in cycle t: rdy_x for affected operands stays 0 at t+1.
- No combinational path from any input to req; all outputs are decoded from registers only.

## Test plan
- Reset mid-operation, with slots busy and shifting -> all outputs 0 within the same cycle and free_cnt=8 after rst deasserts.
- Alloc slot 3 (tag_l=7, tag_r=9, rdy=0/0). Broadcast ch0 tag 7 with dly=8'h04 (L=2) and ch3 tag 9 with dly=8'h01 in the same cycle t -> rdy_r[3] rises at t+1, rdy_l[3] at t+3, req[3] at t+3.
- Alloc slot 0 (tag_l=5) in the same cycle as a ch4 broadcast of tag 5 with dly=8'h01 -> rdy_l[0]=1 at the next cycle, with no lost wakeup.
- Ch2 broadcasts tag 12 with L=3, then cancel_tag=12 one cycle later -> shift_l drops to 0 and rdy_l never rises. A rebroadcast with L=0 -> ready the next cycle.
- Two slots ready; grant slot 1 -> req[1]=0 at the next cycle, req[other] held. Grant to a non-requesting slot 6 -> no state change.
- Fill all 8 slots (free_cnt=0), then free slot 4 together with an alloc to slot 4 in the same cycle -> slot 4 holds the new instruction and free_cnt stays 0.

Source files
------------

// File: rtl/rs_wakeup_shift.sv
// Reservation-station wakeup array: per-operand tag match against result broadcasts
// loads a one-hot latency shift register so dependents wake when the result lands.
module rs_wakeup_shift #(
  parameter int unsigned ENTRIES  = 8,
  parameter int unsigned CHANNELS = 5,
  parameter int unsigned TAG_W    = 5,
  parameter int unsigned DLY_LEN  = 8,
  parameter int unsigned IDX_W    = $clog2(ENTRIES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_vld,
  input  logic [IDX_W-1:0]             alloc_idx,
  input  logic [TAG_W-1:0]             alloc_tag_l,
  input  logic [TAG_W-1:0]             alloc_tag_r,
  input  logic                         alloc_rdy_l,
  input  logic                         alloc_rdy_r,
  input  logic [CHANNELS-1:0]          bcast_vld,
  input  logic [CHANNELS*TAG_W-1:0]    bcast_tag,
  input  logic [CHANNELS*DLY_LEN-1:0]  bcast_dly,
  input  logic                         cancel_vld,
  input  logic [TAG_W-1:0]             cancel_tag,
  input  logic                         grant_vld,
  input  logic [IDX_W-1:0]             grant_idx,
  input  logic                         free_vld,
  input  logic [IDX_W-1:0]             free_idx,
  output logic [ENTRIES-1:0]           req,
  output logic [ENTRIES-1:0]           rdy_l,
  output logic [ENTRIES-1:0]           rdy_r,
  output logic [ENTRIES-1:0]           shift_l,
  output logic [ENTRIES-1:0]           shift_r,
  output logic [ENTRIES-1:0]           busy,
  output logic [IDX_W:0]               free_cnt
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned OP_W  = DLY_LEN + 1;

  logic [ENTRIES-1:0] busy_q, busy_n, issued_q, issued_n;
  logic [ENTRIES-1:0] rdy_l_q, rdy_l_n, rdy_r_q, rdy_r_n;
  logic [TAG_W-1:0]   tag_l_q [ENTRIES];
  logic [TAG_W-1:0]   tag_l_n [ENTRIES];
  logic [TAG_W-1:0]   tag_r_q [ENTRIES];
  logic [TAG_W-1:0]   tag_r_n [ENTRIES];
  logic [DLY_LEN-1:0] sh_l_q  [ENTRIES];
  logic [DLY_LEN-1:0] sh_l_n  [ENTRIES];
  logic [DLY_LEN-1:0] sh_r_q  [ENTRIES];
  logic [DLY_LEN-1:0] sh_r_n  [ENTRIES];
  logic [OP_W-1:0]    al_l, al_r;

  // Returns {hit, dly}; iterating downward lets the lowest matching channel win.
  function automatic logic [OP_W-1:0] bcast_lookup(
    input logic [TAG_W-1:0]            tag,
    input logic [CHANNELS-1:0]         vld,
    input logic [CHANNELS*TAG_W-1:0]   tags,
    input logic [CHANNELS*DLY_LEN-1:0] dlys
  );
    logic [OP_W-1:0] res;
    res = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (vld[c] && (tags[c*TAG_W +: TAG_W] == tag)) res = {1'b1, dlys[c*DLY_LEN +: DLY_LEN]};
    end
    return res;
  endfunction

  // Returns {rdy_q, sh} after one edge; a same-tag broadcast overrides a cancel.
  function automatic logic [OP_W-1:0] op_next(
    input logic               slot_busy,
    input logic               rdy_q,
    input logic [DLY_LEN-1:0] sh,
    input logic [TAG_W-1:0]   tag,
    input logic [OP_W-1:0]    bc,
    input logic               cxl_vld,
    input logic [TAG_W-1:0]   cxl_tag
  );
    logic               cxl;
    logic               rdy_n;
    logic [DLY_LEN-1:0] sh_n;
    cxl   = cxl_vld && (tag == cxl_tag) && !rdy_q && (sh != '0);
    rdy_n = rdy_q;
    sh_n  = sh;
    if (slot_busy && !(rdy_q || sh[0]) && ((sh == '0) || cxl) && bc[DLY_LEN]) begin
      sh_n = bc[DLY_LEN-1:0];
    end else if (cxl) begin
      sh_n = '0;
    end else if (sh != '0) begin
      sh_n  = sh >> 1;
      rdy_n = rdy_q | sh[0];
    end
    return {rdy_n, sh_n};
  endfunction

  // Next-state: alloc > free > (wakeup + grant) per slot.
  always_comb begin
    busy_n   = busy_q;
    issued_n = issued_q;
    rdy_l_n  = rdy_l_q;
    rdy_r_n  = rdy_r_q;
    tag_l_n  = tag_l_q;
    tag_r_n  = tag_r_q;
    sh_l_n   = sh_l_q;
    sh_r_n   = sh_r_q;
    al_l     = bcast_lookup(alloc_tag_l, bcast_vld, bcast_tag, bcast_dly);
    al_r     = bcast_lookup(alloc_tag_r, bcast_vld, bcast_tag, bcast_dly);
    for (int e = 0; e < ENTRIES; e++) begin
      if (alloc_vld && (alloc_idx == IDX_W'(e))) begin
        busy_n[e]   = 1'b1;
        issued_n[e] = 1'b0;
        tag_l_n[e]  = alloc_tag_l;
        tag_r_n[e]  = alloc_tag_r;
        rdy_l_n[e]  = alloc_rdy_l;
        rdy_r_n[e]  = alloc_rdy_r;
        sh_l_n[e]   = (!alloc_rdy_l && al_l[DLY_LEN]) ? al_l[DLY_LEN-1:0] : '0;
        sh_r_n[e]   = (!alloc_rdy_r && al_r[DLY_LEN]) ? al_r[DLY_LEN-1:0] : '0;
      end else if (free_vld && (free_idx == IDX_W'(e))) begin
        busy_n[e]   = 1'b0;
        issued_n[e] = 1'b0;
        rdy_l_n[e]  = 1'b0;
        rdy_r_n[e]  = 1'b0;
        sh_l_n[e]   = '0;
        sh_r_n[e]   = '0;
      end else begin
        {rdy_l_n[e], sh_l_n[e]} = op_next(busy_q[e], rdy_l_q[e], sh_l_q[e], tag_l_q[e],
          bcast_lookup(tag_l_q[e], bcast_vld, bcast_tag, bcast_dly), cancel_vld, cancel_tag);
        {rdy_r_n[e], sh_r_n[e]} = op_next(busy_q[e], rdy_r_q[e], sh_r_q[e], tag_r_q[e],
          bcast_lookup(tag_r_q[e], bcast_vld, bcast_tag, bcast_dly), cancel_vld, cancel_tag);
        if (grant_vld && (grant_idx == IDX_W'(e)) && req[e]) issued_n[e] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      issued_q <= '0;
      rdy_l_q  <= '0;
      rdy_r_q  <= '0;
      for (int e = 0; e < ENTRIES; e++) begin
        tag_l_q[e] <= '0;
        tag_r_q[e] <= '0;
        sh_l_q[e]  <= '0;
        sh_r_q[e]  <= '0;
      end
    end else begin
      busy_q   <= busy_n;
      issued_q <= issued_n;
      rdy_l_q  <= rdy_l_n;
      rdy_r_q  <= rdy_r_n;
      tag_l_q  <= tag_l_n;
      tag_r_q  <= tag_r_n;
      sh_l_q   <= sh_l_n;
      sh_r_q   <= sh_r_n;
    end
  end

  // Output decode, registers only.
  always_comb begin
    free_cnt = CNT_W'(ENTRIES);
    for (int e = 0; e < ENTRIES; e++) begin
      rdy_l[e]   = rdy_l_q[e] | sh_l_q[e][0];
      rdy_r[e]   = rdy_r_q[e] | sh_r_q[e][0];
      shift_l[e] = |sh_l_q[e];
      shift_r[e] = |sh_r_q[e];
      if (busy_q[e]) free_cnt = free_cnt - CNT_W'(1);
    end
  end

  assign busy = busy_q;
  assign req  = busy_q & ~issued_q & rdy_l & rdy_r;

endmodule

// File: tb/tb_rs_wakeup_shift.sv
// Bench for rs_wakeup_shift: directed scenarios plus random traffic against a
// countdown-based operand model.
module tb_rs_wakeup_shift;
  localparam int N = 8, C = 5, TW = 5, DL = 8, IW = 3;

  logic            clk = 1'b0, rst = 1'b0;
  logic            alloc_vld, alloc_rdy_l, alloc_rdy_r;
  logic [IW-1:0]   alloc_idx, grant_idx, free_idx;
  logic [TW-1:0]   alloc_tag_l, alloc_tag_r, cancel_tag;
  logic [C-1:0]    bcast_vld;
  logic [C*TW-1:0] bcast_tag;
  logic [C*DL-1:0] bcast_dly;
  logic            cancel_vld, grant_vld, free_vld;
  logic [N-1:0]    req, rdy_l, rdy_r, shift_l, shift_r, busy;
  logic [IW:0]     free_cnt;

  int checks = 0, errors = 0;

  bit b_vld[C];
  int b_tag[C], b_lat[C];

  // Model: each operand is ready, or pending with cycles-to-go, or waiting.
  bit m_busy[N], m_iss[N], x_busy[N], x_iss[N];
  int m_tag[N][2], x_tag[N][2], m_wait[N][2], x_wait[N][2];
  bit m_rdy[N][2], x_rdy[N][2], m_pend[N][2], x_pend[N][2];

  rs_wakeup_shift #(.ENTRIES(N), .CHANNELS(C), .TAG_W(TW), .DLY_LEN(DL), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .alloc_vld(alloc_vld), .alloc_idx(alloc_idx),
    .alloc_tag_l(alloc_tag_l), .alloc_tag_r(alloc_tag_r),
    .alloc_rdy_l(alloc_rdy_l), .alloc_rdy_r(alloc_rdy_r),
    .bcast_vld(bcast_vld), .bcast_tag(bcast_tag), .bcast_dly(bcast_dly),
    .cancel_vld(cancel_vld), .cancel_tag(cancel_tag),
    .grant_vld(grant_vld), .grant_idx(grant_idx),
    .free_vld(free_vld), .free_idx(free_idx),
    .req(req), .rdy_l(rdy_l), .rdy_r(rdy_r), .shift_l(shift_l), .shift_r(shift_r),
    .busy(busy), .free_cnt(free_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    alloc_vld = 0; alloc_idx = '0; alloc_tag_l = '0; alloc_tag_r = '0;
    alloc_rdy_l = 0; alloc_rdy_r = 0; cancel_vld = 0; cancel_tag = '0;
    grant_vld = 0; grant_idx = '0; free_vld = 0; free_idx = '0;
    for (int c = 0; c < C; c++) begin b_vld[c] = 0; b_tag[c] = 0; b_lat[c] = 0; end
  endtask

  task automatic model_reset();
    for (int e = 0; e < N; e++) begin
      m_busy[e] = 0; m_iss[e] = 0;
      for (int o = 0; o < 2; o++) begin
        m_tag[e][o] = 0; m_rdy[e][o] = 0; m_pend[e][o] = 0; m_wait[e][o] = 0;
      end
    end
  endtask

  function automatic bit m_rdyx(int e, int o);
    return m_rdy[e][o] || (m_pend[e][o] && m_wait[e][o] == 0);
  endfunction

  function automatic bit m_req(int e);
    return m_busy[e] && !m_iss[e] && m_rdyx(e, 0) && m_rdyx(e, 1);
  endfunction

  function automatic int lookup(int tag);
    for (int c = 0; c < C; c++) if (b_vld[c] && b_tag[c] == tag) return b_lat[c];
    return -1;
  endfunction

  task automatic model_next();
    int l; bit rx, cx;
    int at[2]; bit ar[2];
    at[0] = int'(alloc_tag_l); at[1] = int'(alloc_tag_r);
    ar[0] = alloc_rdy_l;       ar[1] = alloc_rdy_r;
    for (int e = 0; e < N; e++) begin
      x_busy[e] = m_busy[e]; x_iss[e] = m_iss[e];
      for (int o = 0; o < 2; o++) begin
        x_tag[e][o] = m_tag[e][o]; x_rdy[e][o] = m_rdy[e][o];
        x_pend[e][o] = m_pend[e][o]; x_wait[e][o] = m_wait[e][o];
      end
      if (alloc_vld && int'(alloc_idx) == e) begin
        x_busy[e] = 1; x_iss[e] = 0;
        for (int o = 0; o < 2; o++) begin
          x_tag[e][o] = at[o]; x_rdy[e][o] = ar[o]; x_pend[e][o] = 0; x_wait[e][o] = 0;
          l = lookup(at[o]);
          if (!ar[o] && l >= 0) begin x_pend[e][o] = 1; x_wait[e][o] = l; end
        end
      end else if (free_vld && int'(free_idx) == e) begin
        x_busy[e] = 0; x_iss[e] = 0;
        for (int o = 0; o < 2; o++) begin x_rdy[e][o] = 0; x_pend[e][o] = 0; end
      end else begin
        if (grant_vld && int'(grant_idx) == e && m_req(e)) x_iss[e] = 1;
        for (int o = 0; o < 2; o++) begin
          l  = lookup(m_tag[e][o]);
          rx = m_rdyx(e, o);
          cx = cancel_vld && int'(cancel_tag) == m_tag[e][o] && !m_rdy[e][o] && m_pend[e][o];
          if (m_busy[e] && !rx && (!m_pend[e][o] || cx) && l >= 0) begin
            x_pend[e][o] = 1; x_wait[e][o] = l;
          end else if (cx) begin
            x_pend[e][o] = 0;
          end else if (m_pend[e][o]) begin
            if (m_wait[e][o] == 0) begin x_rdy[e][o] = 1; x_pend[e][o] = 0; end
            else x_wait[e][o] = m_wait[e][o] - 1;
          end
        end
      end
    end
  endtask

  task automatic model_commit();
    m_busy = x_busy; m_iss = x_iss; m_tag = x_tag;
    m_rdy = x_rdy; m_pend = x_pend; m_wait = x_wait;
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] er, el, erv, esl, esr, eb;
    int cnt;
    cnt = N;
    for (int e = 0; e < N; e++) begin
      er[e] = m_req(e); el[e] = m_rdyx(e, 0); erv[e] = m_rdyx(e, 1);
      esl[e] = m_pend[e][0]; esr[e] = m_pend[e][1]; eb[e] = m_busy[e];
      if (m_busy[e]) cnt--;
    end
    chk({tag, " req"}, 32'(req), 32'(er));
    chk({tag, " rdy_l"}, 32'(rdy_l), 32'(el));
    chk({tag, " rdy_r"}, 32'(rdy_r), 32'(erv));
    chk({tag, " shift_l"}, 32'(shift_l), 32'(esl));
    chk({tag, " shift_r"}, 32'(shift_r), 32'(esr));
    chk({tag, " busy"}, 32'(busy), 32'(eb));
    chk({tag, " free_cnt"}, 32'(free_cnt), 32'(cnt));
  endtask

  task automatic pack_bcast();
    for (int c = 0; c < C; c++) begin
      bcast_vld[c] = b_vld[c];
      bcast_tag[c*TW +: TW] = TW'(b_tag[c]);
      bcast_dly[c*DL +: DL] = DL'(1 << b_lat[c]);
    end
  endtask

  task automatic step(input string tag);
    pack_bcast();
    model_next();
    @(posedge clk);
    model_commit();
    #1;
    clear_in();
    check_model(tag);
  endtask

  task automatic do_alloc(input int idx, input int tl, input int tr, input bit rl, input bit rr);
    alloc_vld = 1; alloc_idx = IW'(idx); alloc_tag_l = TW'(tl); alloc_tag_r = TW'(tr);
    alloc_rdy_l = rl; alloc_rdy_r = rr;
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, " req"}, 32'(req), 0);
    chk({tag, " rdy_l"}, 32'(rdy_l), 0);
    chk({tag, " rdy_r"}, 32'(rdy_r), 0);
    chk({tag, " shift_l"}, 32'(shift_l), 0);
    chk({tag, " shift_r"}, 32'(shift_r), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " free_cnt"}, 32'(free_cnt), N);
  endtask

  initial begin
    clear_in();
    pack_bcast();
    model_reset();
    #1 rst = 1;
    #1 reset_outputs_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 0;

    // Two-channel wakeup with different latencies.
    do_alloc(3, 7, 9, 0, 0); step("A alloc");
    b_vld[0] = 1; b_tag[0] = 7; b_lat[0] = 2;
    b_vld[3] = 1; b_tag[3] = 9; b_lat[3] = 0;
    step("A bcast");
    chk("A rdy_r3 t+1", 32'(rdy_r[3]), 1);
    chk("A rdy_l3 t+1", 32'(rdy_l[3]), 0);
    step("A t+2");
    chk("A rdy_l3 t+2", 32'(rdy_l[3]), 0);
    chk("A req3 t+2", 32'(req[3]), 0);
    step("A t+3");
    chk("A rdy_l3 t+3", 32'(rdy_l[3]), 1);
    chk("A req3 t+3", 32'(req[3]), 1);

    // Broadcast coincident with alloc.
    do_alloc(0, 5, 5, 0, 1);
    b_vld[4] = 1; b_tag[4] = 5; b_lat[4] = 0;
    step("B alloc+bcast");
    chk("B rdy_l0", 32'(rdy_l[0]), 1);
    chk("B req0", 32'(req[0]), 1);

    // Cancel a pending wakeup, then rebroadcast.
    do_alloc(2, 12, 13, 0, 1); step("C alloc");
    b_vld[2] = 1; b_tag[2] = 12; b_lat[2] = 3; step("C bcast");
    chk("C shift_l2", 32'(shift_l[2]), 1);
    cancel_vld = 1; cancel_tag = 12; step("C cancel");
    chk("C shift_l2 cxl", 32'(shift_l[2]), 0);
    chk("C rdy_l2 cxl", 32'(rdy_l[2]), 0);
    for (int i = 0; i < 4; i++) begin
      step("C idle");
      chk("C rdy_l2 idle", 32'(rdy_l[2]), 0);
    end
    b_vld[2] = 1; b_tag[2] = 12; b_lat[2] = 0; step("C rebcast");
    chk("C rdy_l2 rebcast", 32'(rdy_l[2]), 1);

    // Grant handling.
    do_alloc(1, 3, 4, 1, 1); step("D alloc");
    chk("D req1", 32'(req[1]), 1);
    grant_vld = 1; grant_idx = 1; step("D grant1");
    chk("D req1 granted", 32'(req[1]), 0);
    chk("D req0 held", 32'(req[0]), 1);
    grant_vld = 1; grant_idx = 6; step("D grant6");
    chk("D req after grant6", 32'(req), 32'h0d);
    chk("D busy after grant6", 32'(busy), 32'h0f);

    // Fill, then free+alloc the same slot.
    for (int e = 4; e < N; e++) begin do_alloc(e, 20 + e, 21, 0, 0); step("E fill"); end
    chk("E free_cnt full", 32'(free_cnt), 0);
    free_vld = 1; free_idx = 4; do_alloc(4, 1, 2, 1, 1); step("E free+alloc");
    chk("E free_cnt", 32'(free_cnt), 0);
    chk("E busy4", 32'(busy[4]), 1);
    chk("E req4", 32'(req[4]), 1);

    // Reset while slots are busy and shifting.
    free_vld = 1; free_idx = 5; step("F free5");
    do_alloc(5, 25, 26, 0, 1); b_vld[1] = 1; b_tag[1] = 25; b_lat[1] = 6; step("F bcast");
    chk("F shift_l5", 32'(shift_l[5]), 1);
    rst = 1;
    #1 reset_outputs_zero("F mid reset");
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    step("F after reset");
    chk("F free_cnt", 32'(free_cnt), N);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0)
        do_alloc($urandom_range(0, N - 1), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      for (int c = 0; c < C; c++) begin
        b_vld[c] = ($urandom_range(0, 2) == 0);
        b_tag[c] = $urandom_range(0, 15);
        b_lat[c] = $urandom_range(0, DL - 1);
      end
      cancel_vld = ($urandom_range(0, 7) == 0); cancel_tag = TW'($urandom_range(0, 15));
      grant_vld = ($urandom_range(0, 1) == 0); grant_idx = IW'($urandom_range(0, N - 1));
      free_vld = ($urandom_range(0, 5) == 0); free_idx = IW'($urandom_range(0, N - 1));
      step("R");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
